wt_l15_req_arbiter: RTL and testbench
=====================================

# wt_l15_req_arbiter

Arbitrates the three write-through cache miss/store sources (icache fill, dcache load miss, dcache write-through store) onto the single L1.5 request channel of the OpenPiton NoC interface. It sits between the WT cache subsystem and the L1.5 adapter. It applies round-robin fairness and throttles stores to the configured outstanding-store limit. It owns a one-entry output register and the outstanding-store counter used for fence/flush completion.

## Interface
- MaxOutstandingStores, 7, store grants allowed before `store_ack_i` returns; range 1..15
- MemTidWidth, 2, transaction ID width
- AddrWidth, 64, physical address width
- DataWidth, 64, store data width; BE width is DataWidth/8
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ifill_valid_i / ifill_ready_o  in/out  1  icache fill request handshake
- ifill_addr_i, ifill_tid_i  in  AddrWidth, MemTidWidth  icache payload
- ld_valid_i / ld_ready_o  in/out  1  dcache load-miss handshake
- ld_addr_i, ld_size_i, ld_tid_i  in  AddrWidth, 3, MemTidWidth  load payload
- st_valid_i / st_ready_o  in/out  1  dcache store handshake
- st_addr_i, st_data_i, st_be_i, st_tid_i  in  AddrWidth, DataWidth, DataWidth/8, MemTidWidth  store payload
- l15_valid_o / l15_ready_i  out/in  1  L1.5 request handshake
- l15_type_o  out  2  request type: IFILL=0, LOAD=1, STORE=2
- l15_addr_o, l15_data_o, l15_be_o, l15_size_o, l15_tid_o  out  matching widths  registered payload; l15_size_o is 3 for IFILL, ld_size_i for LOAD, 0 for STORE
- store_ack_i  in  1  one store completion per cycle from L1.5 response path
- st_cnt_o  out  $clog2(MaxOutstandingStores+1)  outstanding stores
- stores_empty_o  out  1  `st_cnt_o == 0`

## Operation
- Output register free when `!l15_valid_o || l15_ready_i`.
- Eligibility: IFILL and LOAD are eligible when their valid is high. STORE is eligible when `st_valid_i && st_cnt_o < MaxOutstandingStores`.
- Round-robin order 0=IFILL, 1=LOAD, 2=STORE. Pointer `rr_q` names the highest-priority source.
- Winner: the first eligible source starting at `rr_q`, wrapping 2→0.
- If the output register is free and a winner exists, assert only the winner's `*_ready_o`. Load its payload into the output register with `l15_type_o` set to the winner index. Set `rr_q` = (winner+1) mod 3.
- No winner: `rr_q` holds; the register clears valid if drained.
- `*_ready_o` is combinational from valids, `rr_q`, `st_cnt_o` and `l15_ready_i`. Requesters hold payload stable while valid && !ready. Valid never depends on ready.
- Store counter:
  - +1 on STORE grant; −1 on `store_ack_i`.
  - Grant and ack in the same cycle: net unchanged.
  - Ack at count 0: ignored, counter stays 0.
  - A grant at count == MaxOutstandingStores is impossible by eligibility.
- Payload fields unused by a type are driven 0: data and BE on IFILL/LOAD.

## Timing
- Reset values: `l15_valid_o`=0, all payload 0, `l15_type_o`=0, `rr_q`=0, `st_cnt_o`=0, `stores_empty_o`=1. Ready outputs are 0 while in reset.
- Latency: a grant in cycle N gives `l15_valid_o`=1 in N+1.
- Throughput: one request per cycle while `l15_ready_i` stays high.
- Backpressure: `l15_valid_o` and payload are held stable until `l15_ready_i`. No requester is granted while the register is full and not draining.
- A store granted in N is counted from N+1. An ack in N is reflected in N+1. `stores_empty_o` follows the same cycle timing.
- Reset mid-operation: the pending output request is dropped and the counter is cleared. Upstream must re-issue.

## Structure
- The request-type enum (IFILL/LOAD/STORE) and the width helper for `st_cnt_o` go in `wt_cache_pkg`.
- One sub-module, `wt_rr_pick3`: combinational 3-way round-robin picker. Inputs: eligible vector and `rr_q`. Outputs: one-hot grant and winner index.
- Top level: output register, `rr_q` register, store counter.

## Test plan
- All three valid, `l15_ready_i`=1, from reset → grants in order IFILL, LOAD, STORE, IFILL on consecutive cycles; output types 0,1,2,0 starting one cycle later.
- Only stores valid, no acks, MaxOutstandingStores=7 → exactly 7 grants, then `st_ready_o`=0 with `st_cnt_o`=7. One `store_ack_i` → one more grant next cycle.
- `l15_ready_i`=0 for 5 cycles with load pending → `l15_valid_o` and payload stable, all readies 0. Ready returns → a new grant is taken in that same cycle.
- Store grant and `store_ack_i` in the same cycle at count 3 → count stays 3. Ack at count 0 → stays 0, `stores_empty_o`=1.
- Store throttled at 7 while IFILL and LOAD valid → IFILL and LOAD alternate and are not blocked by the stalled store.
- Assert `rst_ni` low while `l15_valid_o`=1 and count=4 → asynchronous clear to all reset values without waiting for a clock edge.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Request-type encoding and store-counter sizing shared by the WT cache L1.5 request path.
package wt_cache_pkg;

  typedef enum logic [1:0] {
    L15_IFILL = 2'd0,
    L15_LOAD  = 2'd1,
    L15_STORE = 2'd2
  } l15_req_e;

  function automatic int unsigned st_cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/wt_rr_pick3.sv
// Combinational 3-way round-robin picker: first eligible source starting at rr_q, wrapping 2->0.
module wt_rr_pick3 (
  input  logic [2:0] eligible,
  input  logic [1:0] rr_q,
  output logic [2:0] grant,
  output logic [1:0] winner,
  output logic       any_grant
);

  logic [1:0] ord0, ord1, ord2;

  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (rr_q)
      2'd1: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd2: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: ;
    endcase

    grant     = 3'b000;
    winner    = 2'd0;
    any_grant = 1'b0;
    if (eligible[ord0]) begin
      winner    = ord0;
      any_grant = 1'b1;
    end else if (eligible[ord1]) begin
      winner    = ord1;
      any_grant = 1'b1;
    end else if (eligible[ord2]) begin
      winner    = ord2;
      any_grant = 1'b1;
    end
    if (any_grant) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/wt_l15_req_arbiter.sv
// Round-robin arbiter of icache fill, dcache load miss and dcache store onto the L1.5 request
// channel, with a one-entry output register and an outstanding-store throttle counter.
module wt_l15_req_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned MemTidWidth          = 2,
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           ifill_valid_i,
  output logic                                           ifill_ready_o,
  input  logic [AddrWidth-1:0]                           ifill_addr_i,
  input  logic [MemTidWidth-1:0]                         ifill_tid_i,
  input  logic                                           ld_valid_i,
  output logic                                           ld_ready_o,
  input  logic [AddrWidth-1:0]                           ld_addr_i,
  input  logic [2:0]                                     ld_size_i,
  input  logic [MemTidWidth-1:0]                         ld_tid_i,
  input  logic                                           st_valid_i,
  output logic                                           st_ready_o,
  input  logic [AddrWidth-1:0]                           st_addr_i,
  input  logic [DataWidth-1:0]                           st_data_i,
  input  logic [DataWidth/8-1:0]                         st_be_i,
  input  logic [MemTidWidth-1:0]                         st_tid_i,
  output logic                                           l15_valid_o,
  input  logic                                           l15_ready_i,
  output logic [1:0]                                     l15_type_o,
  output logic [AddrWidth-1:0]                           l15_addr_o,
  output logic [DataWidth-1:0]                           l15_data_o,
  output logic [DataWidth/8-1:0]                         l15_be_o,
  output logic [2:0]                                     l15_size_o,
  output logic [MemTidWidth-1:0]                         l15_tid_o,
  input  logic                                           store_ack_i,
  output logic [st_cnt_width(MaxOutstandingStores)-1:0]  st_cnt_o,
  output logic                                           stores_empty_o
);

  localparam int unsigned   CntW    = st_cnt_width(MaxOutstandingStores);
  localparam logic [CntW-1:0] StMax = CntW'(MaxOutstandingStores);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [1:0]             rr_q, rr_nxt;
  logic [CntW-1:0]        st_cnt_q;
  logic [2:0]             eligible, grant;
  logic [1:0]             winner;
  logic                   any_grant, reg_free, do_grant, st_inc, st_dec;

  logic                   vld_p1;
  logic [1:0]             type_p1;
  logic [AddrWidth-1:0]   addr_p1, nxt_addr;
  logic [DataWidth-1:0]   data_p1, nxt_data;
  logic [DataWidth/8-1:0] be_p1, nxt_be;
  logic [2:0]             size_p1, nxt_size;
  logic [MemTidWidth-1:0] tid_p1, nxt_tid;

  assign eligible = {st_valid_i && (st_cnt_q < StMax), ld_valid_i, ifill_valid_i};

  wt_rr_pick3 u_pick (
    .eligible  (eligible),
    .rr_q      (rr_q),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // Readies are held low during reset so nothing is handed off while state is being cleared.
  assign reg_free      = !vld_p1 || l15_ready_i;
  assign do_grant      = rst_ni && reg_free && any_grant;
  assign ifill_ready_o = do_grant && grant[0];
  assign ld_ready_o    = do_grant && grant[1];
  assign st_ready_o    = do_grant && grant[2];

  assign st_inc = do_grant && grant[2];
  assign st_dec = store_ack_i && (st_cnt_q != '0);

  always_comb begin
    rr_nxt = 2'd0;
    case (winner)
      2'd0:    rr_nxt = 2'd1;
      2'd1:    rr_nxt = 2'd2;
      default: rr_nxt = 2'd0;
    endcase
  end

  always_comb begin
    nxt_addr = ifill_addr_i;
    nxt_data = '0;
    nxt_be   = '0;
    nxt_size = 3'd3;
    nxt_tid  = ifill_tid_i;
    case (winner)
      L15_LOAD: begin
        nxt_addr = ld_addr_i;
        nxt_size = ld_size_i;
        nxt_tid  = ld_tid_i;
      end
      L15_STORE: begin
        nxt_addr = st_addr_i;
        nxt_data = st_data_i;
        nxt_be   = st_be_i;
        nxt_size = 3'd0;
        nxt_tid  = st_tid_i;
      end
      default: ;
    endcase
  end

  // Stage p1: output register, round-robin pointer and outstanding-store count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      rr_q     <= 2'd0;
      st_cnt_q <= '0;
    end else begin
      if (do_grant) begin
        vld_p1 <= 1'b1;
        rr_q   <= rr_nxt;
      end else if (l15_ready_i) begin
        vld_p1 <= 1'b0;
      end
      if (st_inc && !st_dec)      st_cnt_q <= st_cnt_q + CntOne;
      else if (!st_inc && st_dec) st_cnt_q <= st_cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      type_p1 <= 2'd0;
      addr_p1 <= '0;
      data_p1 <= '0;
      be_p1   <= '0;
      size_p1 <= 3'd0;
      tid_p1  <= '0;
    end else if (do_grant) begin
      type_p1 <= winner;
      addr_p1 <= nxt_addr;
      data_p1 <= nxt_data;
      be_p1   <= nxt_be;
      size_p1 <= nxt_size;
      tid_p1  <= nxt_tid;
    end
  end

  assign l15_valid_o    = vld_p1;
  assign l15_type_o     = type_p1;
  assign l15_addr_o     = addr_p1;
  assign l15_data_o     = data_p1;
  assign l15_be_o       = be_p1;
  assign l15_size_o     = size_p1;
  assign l15_tid_o      = tid_p1;
  assign st_cnt_o       = st_cnt_q;
  assign stores_empty_o = (st_cnt_q == '0);

endmodule

// File: tb/tb_wt_l15_req_arbiter.sv
// Scenario bench for wt_l15_req_arbiter: expected L1.5 requests queued at grant, checked at hand-off.
module tb_wt_l15_req_arbiter;

  localparam int unsigned MaxSt = 7;
  localparam int unsigned TidW  = 2;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            ifill_valid = 1'b0, ld_valid = 1'b0, st_valid = 1'b0;
  logic            ifill_ready, ld_ready, st_ready;
  logic [AW-1:0]   ifill_addr = '0, ld_addr = '0, st_addr = '0;
  logic [TidW-1:0] ifill_tid = '0, ld_tid = '0, st_tid = '0;
  logic [2:0]      ld_size = 3'd0;
  logic [DW-1:0]   st_data = '0;
  logic [DW/8-1:0] st_be = '0;
  logic            l15_valid, l15_ready = 1'b0;
  logic [1:0]      l15_type;
  logic [AW-1:0]   l15_addr;
  logic [DW-1:0]   l15_data;
  logic [DW/8-1:0] l15_be;
  logic [2:0]      l15_size;
  logic [TidW-1:0] l15_tid;
  logic            store_ack = 1'b0;
  logic [2:0]      st_cnt;
  logic            stores_empty;

  typedef struct packed {
    logic [1:0]      typ;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [2:0]      size;
    logic [TidW-1:0] tid;
  } req_t;

  req_t       sb[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [2:0] model_cnt = 3'd0;

  always #5 clk = ~clk;

  wt_l15_req_arbiter #(
    .MaxOutstandingStores (MaxSt),
    .MemTidWidth          (TidW),
    .AddrWidth            (AW),
    .DataWidth            (DW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ifill_valid_i  (ifill_valid),
    .ifill_ready_o  (ifill_ready),
    .ifill_addr_i   (ifill_addr),
    .ifill_tid_i    (ifill_tid),
    .ld_valid_i     (ld_valid),
    .ld_ready_o     (ld_ready),
    .ld_addr_i      (ld_addr),
    .ld_size_i      (ld_size),
    .ld_tid_i       (ld_tid),
    .st_valid_i     (st_valid),
    .st_ready_o     (st_ready),
    .st_addr_i      (st_addr),
    .st_data_i      (st_data),
    .st_be_i        (st_be),
    .st_tid_i       (st_tid),
    .l15_valid_o    (l15_valid),
    .l15_ready_i    (l15_ready),
    .l15_type_o     (l15_type),
    .l15_addr_o     (l15_addr),
    .l15_data_o     (l15_data),
    .l15_be_o       (l15_be),
    .l15_size_o     (l15_size),
    .l15_tid_o      (l15_tid),
    .store_ack_i    (store_ack),
    .st_cnt_o       (st_cnt),
    .stores_empty_o (stores_empty)
  );

  function automatic req_t mk_req(input logic [2:0] onehot);
    req_t r;
    r = '0;
    if (onehot[0]) begin
      r.typ = 2'd0; r.addr = ifill_addr; r.size = 3'd3; r.tid = ifill_tid;
    end else if (onehot[1]) begin
      r.typ = 2'd1; r.addr = ld_addr; r.size = ld_size; r.tid = ld_tid;
    end else begin
      r.typ = 2'd2; r.addr = st_addr; r.data = st_data; r.be = st_be; r.tid = st_tid;
    end
    return r;
  endfunction

  function automatic req_t observed();
    return {l15_type, l15_addr, l15_data, l15_be, l15_size, l15_tid};
  endfunction

  task automatic refresh(input logic [2:0] onehot);
    if (onehot[0]) begin
      ifill_addr = {$urandom, $urandom}; ifill_tid = TidW'($urandom);
    end
    if (onehot[1]) begin
      ld_addr = {$urandom, $urandom}; ld_size = 3'($urandom_range(7)); ld_tid = TidW'($urandom);
    end
    if (onehot[2]) begin
      st_addr = {$urandom, $urandom}; st_data = {$urandom, $urandom};
      st_be = 8'($urandom); st_tid = TidW'($urandom);
    end
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic cycle(input logic [2:0] exp_rdy);
    req_t want, got;
    logic [2:0] nxt;
    #1;
    n_vec++;
    if ({st_ready, ld_ready, ifill_ready} !== exp_rdy) begin
      n_miss++;
      $display("FAIL ready_vec: got %b, expected %b (t=%0t)", {st_ready, ld_ready, ifill_ready}, exp_rdy, $time);
    end
    n_vec++;
    if (st_cnt !== model_cnt) begin
      n_miss++;
      $display("FAIL st_cnt: got %0d, expected %0d (t=%0t)", st_cnt, model_cnt, $time);
    end
    n_vec++;
    if (stores_empty !== (model_cnt == 3'd0)) begin
      n_miss++;
      $display("FAIL stores_empty: got %b, expected %b (t=%0t)", stores_empty, (model_cnt == 3'd0), $time);
    end
    if (l15_valid && l15_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_req: got type %0d with nothing expected (t=%0t)", l15_type, $time);
      end else begin
        want = sb.pop_front();
        got  = observed();
        if (got !== want) begin
          n_miss++;
          $display("FAIL l15_req: got %h, expected %h (t=%0t)", got, want, $time);
        end
      end
    end
    if (exp_rdy != 3'b000) sb.push_back(mk_req(exp_rdy));
    nxt = model_cnt;
    if (exp_rdy[2]) nxt = nxt + 3'd1;
    if (store_ack && model_cnt != 3'd0) nxt = nxt - 3'd1;
    model_cnt = nxt;
    @(posedge clk);
    #1;
    refresh(exp_rdy);
    @(negedge clk);
  endtask

  task automatic set_in(input logic iv, input logic lv, input logic sv, input logic rdy, input logic ack);
    ifill_valid = iv; ld_valid = lv; st_valid = sv; l15_ready = rdy; store_ack = ack;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    n_vec++;
    if ({st_ready, ld_ready, ifill_ready} !== 3'b000) begin
      n_miss++;
      $display("FAIL reset_ready: got %b, expected 000", {st_ready, ld_ready, ifill_ready});
    end
    n_vec++;
    if (l15_valid !== 1'b0 || observed() !== '0) begin
      n_miss++;
      $display("FAIL reset_out: got valid %b req %h, expected valid 0 req 0", l15_valid, observed());
    end
    n_vec++;
    if (st_cnt !== 3'd0 || stores_empty !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_cnt: got cnt %0d empty %b, expected 0 and 1", st_cnt, stores_empty);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_rr_order();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(3'b001);
    n_vec++;
    if (l15_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL first_latency: got l15_valid %b, expected 1", l15_valid);
    end
    cycle(3'b010);
    cycle(3'b100);
    cycle(3'b001);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(3'b000);
    cycle(3'b000);
  endtask

  task automatic test_store_throttle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(3'b000);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(3'b100);
    cycle(3'b000);
    cycle(3'b000);
    store_ack = 1'b1;
    cycle(3'b000);
    store_ack = 1'b0;
    cycle(3'b100);
    cycle(3'b000);
  endtask

  task automatic test_throttle_fairness();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(3'b001);
    cycle(3'b010);
    cycle(3'b001);
    cycle(3'b010);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(3'b000);
    cycle(3'b000);
  endtask

  task automatic test_grant_ack_same_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(3'b000);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(3'b100);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(3'b000);
    store_ack = 1'b1;
    for (int i = 0; i < 4; i++) cycle(3'b000);
    store_ack = 1'b0;
    cycle(3'b000);
  endtask

  task automatic test_backpressure();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(3'b010);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++;
      if (l15_valid !== 1'b1) begin
        n_miss++;
        $display("FAIL stall_valid: got %b, expected 1 (stall %0d)", l15_valid, k);
      end
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL stall_payload: got %h, expected a held load request", observed());
      end else if (observed() !== sb[0]) begin
        n_miss++;
        $display("FAIL stall_payload: got %h, expected %h (stall %0d)", observed(), sb[0], k);
      end
      cycle(3'b000);
    end
    l15_ready = 1'b1;
    cycle(3'b010);
    ld_valid = 1'b0;
    cycle(3'b000);
    cycle(3'b000);
  endtask

  task automatic test_async_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(3'b100);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (l15_valid !== 1'b1 || st_cnt !== 3'd4) begin
      n_miss++;
      $display("FAIL pre_reset: got valid %b cnt %0d, expected valid 1 cnt 4", l15_valid, st_cnt);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (l15_valid !== 1'b0 || observed() !== '0) begin
      n_miss++;
      $display("FAIL async_clear_out: got valid %b req %h, expected valid 0 req 0", l15_valid, observed());
    end
    n_vec++;
    if (st_cnt !== 3'd0 || stores_empty !== 1'b1) begin
      n_miss++;
      $display("FAIL async_clear_cnt: got cnt %0d empty %b, expected 0 and 1", st_cnt, stores_empty);
    end
    n_vec++;
    if ({st_ready, ld_ready, ifill_ready} !== 3'b000) begin
      n_miss++;
      $display("FAIL async_ready: got %b, expected 000", {st_ready, ld_ready, ifill_ready});
    end
    sb.delete();
    model_cnt = 3'd0;
    @(negedge clk);
    rst_ni = 1'b1;
    l15_ready = 1'b1;
    cycle(3'b001);
    ifill_valid = 1'b0;
    cycle(3'b000);
    cycle(3'b000);
  endtask

  initial begin
    refresh(3'b111);
    test_reset();
    test_rr_order();
    test_store_throttle();
    test_throttle_fairness();
    test_grant_ack_same_cycle();
    test_backpressure();
    test_async_reset();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL sb_drained: got %0d requests still expected, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
